// File: rtl/wb_stage_pipe.sv
// MEM->WB writeback register bank, DEPTH (1..4) stages with stall/flush and x0 write suppression.
// Optional RETIRE_CNT_EN macro adds a 64-bit retire counter output retire_cnt_o.
module wb_stage_pipe #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              wen_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XLEN-1:0]   pc_i,
    output logic              valid_o,
    output logic [REG_AW-1:0] rd_o,
    output logic              wen_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic [XLEN-1:0]   pc_o,
    output logic              retire_o
`ifdef RETIRE_CNT_EN
    ,
    output logic [63:0]       retire_cnt_o
`endif
);

    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
        $error("wb_stage_pipe: DEPTH must be in 1..4");
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic              vld_p;
        logic [REG_AW-1:0] rd_p;
        logic              wen_p;
        logic [XLEN-1:0]   wdata_p;
        logic [XLEN-1:0]   pc_p;

        if (g == 0) begin : g_first
            // Stage 0 boundary: writes to x0 are dropped here so no later stage can carry them
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p   <= 1'b0;
                    rd_p    <= '0;
                    wen_p   <= 1'b0;
                    wdata_p <= '0;
                    pc_p    <= '0;
                end else if (flush_i) begin
                    vld_p   <= 1'b0;
                    rd_p    <= '0;
                    wen_p   <= 1'b0;
                    wdata_p <= '0;
                    pc_p    <= '0;
                end else if (!stall_i) begin
                    vld_p   <= valid_i;
                    rd_p    <= rd_i;
                    wen_p   <= wen_i & valid_i & (rd_i != '0);
                    wdata_p <= wdata_i;
                    pc_p    <= pc_i;
                end
            end
        end else begin : g_next
            // Stage g boundary: shift from the previous stage; flush takes priority over stall
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p   <= 1'b0;
                    rd_p    <= '0;
                    wen_p   <= 1'b0;
                    wdata_p <= '0;
                    pc_p    <= '0;
                end else if (flush_i) begin
                    vld_p   <= 1'b0;
                    rd_p    <= '0;
                    wen_p   <= 1'b0;
                    wdata_p <= '0;
                    pc_p    <= '0;
                end else if (!stall_i) begin
                    vld_p   <= g_stage[g-1].vld_p;
                    rd_p    <= g_stage[g-1].rd_p;
                    wen_p   <= g_stage[g-1].wen_p;
                    wdata_p <= g_stage[g-1].wdata_p;
                    pc_p    <= g_stage[g-1].pc_p;
                end
            end
        end
    end

    assign valid_o  = g_stage[DEPTH-1].vld_p;
    assign rd_o     = g_stage[DEPTH-1].rd_p;
    assign wen_o    = g_stage[DEPTH-1].wen_p & g_stage[DEPTH-1].vld_p;
    assign wdata_o  = g_stage[DEPTH-1].wdata_p;
    assign pc_o     = g_stage[DEPTH-1].pc_p;
    assign retire_o = valid_o & ~stall_i & ~flush_i;

`ifdef RETIRE_CNT_EN
    // Counts retirements only; flush does not clear it and a stall simply produces no pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_o <= '0;
        end else if (retire_o) begin
            retire_cnt_o <= retire_cnt_o + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe: two instances (DEPTH=2 and DEPTH=3) share one stimulus.
module tb_wb_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, flush_i, valid_i, wen_i;
    logic [4:0]  rd_i;
    logic [31:0] wdata_i, pc_i;

    logic        v2, w2, r2, v3, w3, r3;
    logic [4:0]  rd2, rd3;
    logic [31:0] d2, d3, p2, p3;
`ifdef RETIRE_CNT_EN
    logic [63:0] c2, c3;
`endif

    int tests = 0;
    int fails = 0;
    int retires;

    always #5 clk = ~clk;

    wb_stage_pipe #(.XLEN(32), .REG_AW(5), .DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .rd_i(rd_i), .wen_i(wen_i), .wdata_i(wdata_i), .pc_i(pc_i),
        .valid_o(v2), .rd_o(rd2), .wen_o(w2), .wdata_o(d2), .pc_o(p2), .retire_o(r2)
`ifdef RETIRE_CNT_EN
        , .retire_cnt_o(c2)
`endif
    );

    wb_stage_pipe #(.XLEN(32), .REG_AW(5), .DEPTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .rd_i(rd_i), .wen_i(wen_i), .wdata_i(wdata_i), .pc_i(pc_i),
        .valid_o(v3), .rd_o(rd3), .wen_o(w3), .wdata_o(d3), .pc_o(p3), .retire_o(r3)
`ifdef RETIRE_CNT_EN
        , .retire_cnt_o(c3)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [4:0] rd,
                         input logic [31:0] d, input logic [31:0] p);
        valid_i = v; wen_i = w; rd_i = rd; wdata_i = d; pc_i = p;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        stall_i = 1'b0; flush_i = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall_i = 1'b0; flush_i = 1'b0;
        drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 32'h100);
        tick();
        tests++; if ({v2, rd2, w2, d2, p2, r2} !== '0) begin fails++; $display("FAIL reset_hold dut2 got v=%b rd=%0d d=%h exp all 0", v2, rd2, d2); end
        tests++; if ({v3, rd3, w3, d3, p3, r3} !== '0) begin fails++; $display("FAIL reset_hold dut3 got v=%b rd=%0d d=%h exp all 0", v3, rd3, d3); end
        rst_n = 1'b1;
        tick(); tick();
        tests++; if (v2 !== 1'b1 || rd2 !== 5'd5 || d2 !== 32'hDEADBEEF) begin fails++; $display("FAIL pre_reset_fill got v=%b rd=%0d d=%h exp 1/5/deadbeef", v2, rd2, d2); end
        rst_n = 1'b0;
        #2;
        tests++; if ({v2, rd2, w2, d2, p2, r2} !== '0) begin fails++; $display("FAIL async_reset dut2 got v=%b rd=%0d w=%b d=%h p=%h r=%b exp all 0", v2, rd2, w2, d2, p2, r2); end
        tests++; if ({v3, rd3, w3, d3, p3, r3} !== '0) begin fails++; $display("FAIL async_reset dut3 got v=%b rd=%0d d=%h exp all 0", v3, rd3, d3); end
        rst_n = 1'b1;
        tick();
        tests++; if (v2 !== 1'b0) begin fails++; $display("FAIL reset_latency1 got v=%b exp 0", v2); end
        tick();
        tests++; if (v2 !== 1'b1 || rd2 !== 5'd5 || w2 !== 1'b1 || d2 !== 32'hDEADBEEF || p2 !== 32'h100 || r2 !== 1'b1)
            begin fails++; $display("FAIL reset_latency2 got v=%b rd=%0d w=%b d=%h p=%h r=%b exp 1/5/1/deadbeef/100/1", v2, rd2, w2, d2, p2, r2); end
`ifdef RETIRE_CNT_EN
        tests++; if (c3 !== 64'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", c3); end
`endif
    endtask

    task automatic test_latency();
        do_reset();
        drive(1'b1, 1'b1, 5'd1, 32'h11, 32'h1004); tick();
        drive(1'b1, 1'b1, 5'd2, 32'h22, 32'h1008); tick();
        drive(1'b1, 1'b1, 5'd3, 32'h33, 32'h100C); tick();
        tests++; if (v3 !== 1'b1 || rd3 !== 5'd1 || w3 !== 1'b1 || d3 !== 32'h11 || p3 !== 32'h1004 || r3 !== 1'b1)
            begin fails++; $display("FAIL lat_c3 got v=%b rd=%0d w=%b d=%h p=%h r=%b exp 1/1/1/11/1004/1", v3, rd3, w3, d3, p3, r3); end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0); tick();
        tests++; if (rd3 !== 5'd2 || d3 !== 32'h22 || r3 !== 1'b1) begin fails++; $display("FAIL lat_c4 got rd=%0d d=%h r=%b exp 2/22/1", rd3, d3, r3); end
        tests++; if (rd2 !== 5'd3 || d2 !== 32'h33) begin fails++; $display("FAIL lat_d2_c4 got rd=%0d d=%h exp 3/33", rd2, d2); end
        tick();
        tests++; if (rd3 !== 5'd3 || d3 !== 32'h33 || p3 !== 32'h100C || r3 !== 1'b1) begin fails++; $display("FAIL lat_c5 got rd=%0d d=%h p=%h r=%b exp 3/33/100c/1", rd3, d3, p3, r3); end
        tick();
        tests++; if (v3 !== 1'b0 || r3 !== 1'b0) begin fails++; $display("FAIL lat_drain got v=%b r=%b exp 0/0", v3, r3); end
`ifdef RETIRE_CNT_EN
        tests++; if (c3 !== 64'd3) begin fails++; $display("FAIL lat_cnt3 got %0d exp 3", c3); end
        tests++; if (c2 !== 64'd3) begin fails++; $display("FAIL lat_cnt2 got %0d exp 3", c2); end
`endif
    endtask

    task automatic test_stall();
        do_reset();
        drive(1'b1, 1'b1, 5'd7, 32'h77, 32'h700); tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0); tick();
        stall_i = 1'b1;
        #1;
        retires = 0;
        tests++; if (r2 !== 1'b0) begin fails++; $display("FAIL stall_retire_comb got %b exp 0", r2); end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (r2 === 1'b1) retires++;
            tests++; if (v2 !== 1'b1 || rd2 !== 5'd7 || w2 !== 1'b1 || d2 !== 32'h77 || p2 !== 32'h700 || r2 !== 1'b0)
                begin fails++; $display("FAIL stall_hold[%0d] got v=%b rd=%0d w=%b d=%h p=%h r=%b exp 1/7/1/77/700/0", i, v2, rd2, w2, d2, p2, r2); end
        end
        stall_i = 1'b0;
        #1;
        if (r2 === 1'b1) retires++;
        tick();
        if (r2 === 1'b1) retires++;
        tests++; if (v2 !== 1'b0) begin fails++; $display("FAIL stall_release got v=%b exp 0", v2); end
        tests++; if (retires != 1) begin fails++; $display("FAIL stall_retire_once got %0d pulses exp 1", retires); end
    endtask

    task automatic test_flush_priority();
        do_reset();
        drive(1'b1, 1'b1, 5'd1, 32'hA1, 32'h10); tick();
        drive(1'b1, 1'b1, 5'd2, 32'hA2, 32'h14); tick();
        drive(1'b1, 1'b1, 5'd3, 32'hA3, 32'h18); tick();
        stall_i = 1'b1; flush_i = 1'b1;
        #1;
        tests++; if (r2 !== 1'b0 || r3 !== 1'b0) begin fails++; $display("FAIL flush_no_retire got r2=%b r3=%b exp 0/0", r2, r3); end
        tick();
        stall_i = 1'b0; flush_i = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        #1;
        tests++; if ({v3, w3, rd3, d3, p3, r3} !== '0) begin fails++; $display("FAIL flush_dut3 got v=%b w=%b rd=%0d d=%h r=%b exp all 0", v3, w3, rd3, d3, r3); end
        tests++; if ({v2, w2, rd2, d2, p2, r2} !== '0) begin fails++; $display("FAIL flush_dut2 got v=%b w=%b rd=%0d d=%h r=%b exp all 0", v2, w2, rd2, d2, r2); end
        tick();
        tests++; if (v3 !== 1'b0 || v2 !== 1'b0) begin fails++; $display("FAIL flush_inner got v3=%b v2=%b exp 0/0", v3, v2); end
`ifdef RETIRE_CNT_EN
        tests++; if (c3 !== 64'd0) begin fails++; $display("FAIL flush_cnt got %0d exp 0", c3); end
`endif
    endtask

    task automatic test_x0();
        do_reset();
        drive(1'b1, 1'b1, 5'd0, 32'h12345678, 32'h200); tick();
        drive(1'b1, 1'b0, 5'd4, 32'h44, 32'h204); tick();
        tests++; if (w2 !== 1'b0 || v2 !== 1'b1 || r2 !== 1'b1 || d2 !== 32'h12345678)
            begin fails++; $display("FAIL x0_dut2 got w=%b v=%b r=%b d=%h exp 0/1/1/12345678", w2, v2, r2, d2); end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0); tick();
        tests++; if (w3 !== 1'b0 || v3 !== 1'b1 || r3 !== 1'b1 || rd3 !== 5'd0)
            begin fails++; $display("FAIL x0_dut3 got w=%b v=%b r=%b rd=%0d exp 0/1/1/0", w3, v3, r3, rd3); end
        tests++; if (w2 !== 1'b0 || v2 !== 1'b1 || rd2 !== 5'd4) begin fails++; $display("FAIL nowen got w=%b v=%b rd=%0d exp 0/1/4", w2, v2, rd2); end
    endtask

    task automatic test_bubble();
        do_reset();
        drive(1'b0, 1'b1, 5'd9, 32'h99, 32'h300); tick(); tick();
        tests++; if (v2 !== 1'b0 || w2 !== 1'b0 || r2 !== 1'b0) begin fails++; $display("FAIL bubble_dut2 got v=%b w=%b r=%b exp 0/0/0", v2, w2, r2); end
        tick();
        tests++; if (v3 !== 1'b0 || w3 !== 1'b0 || r3 !== 1'b0) begin fails++; $display("FAIL bubble_dut3 got v=%b w=%b r=%b exp 0/0/0", v3, w3, r3); end
`ifdef RETIRE_CNT_EN
        tests++; if (c3 !== 64'd0) begin fails++; $display("FAIL bubble_cnt got %0d exp 0", c3); end
`endif
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stall();
        test_flush_priority();
        test_x0();
        test_bubble();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
